md_unit: RTL and testbench

Iterative unsigned multiply/divide unit. It sits directly upstream of the register file write port. It accepts one operation from the decode/execute logic, computes it over a fixed number of cycles, and delivers the result as a one-cycle register write. Its outputs connect straight to the register file's `writeReg`, `writeData` and `writeEnable` inputs. While it works, `busy` stalls the issuing logic.

---
 rtl/md_pkg.sv | 18 +
 rtl/md_unit.sv | 135 +++++++++++++
 tb/tb_md_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_WIDTH  = 32;
    localparam int unsigned MD_REG_AW = 5;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdState_t;

endpackage

// File: rtl/md_unit.sv
// Iterative unsigned multiply/divide unit feeding the register file write port.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH  = MD_WIDTH,
    parameter int unsigned REG_AW = MD_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  srcA,
    input  logic [WIDTH-1:0]  srcB,
    input  logic [REG_AW-1:0] destReg,
    output logic              busy,
    output logic              writeEnable,
    output logic [REG_AW-1:0] writeReg,
    output logic [WIDTH-1:0]  writeData
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    mdState_t          state, stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        opQ;
    logic [WIDTH-1:0]  bQ;
    logic [REG_AW-1:0] destQ;
    logic [WIDTH-1:0]  accHi, accLo;
    logic [WIDTH-1:0]  hiNext, loNext, result, addend;
    logic [WIDTH:0]    sum, shifted, diff;
    logic              accept, iterate, finish;
    logic              busyQ, weQ;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic; abort overrides every transition, including accept.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        iterate   = 1'b0;
        finish    = 1'b0;
        if (abort) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stateNext = CALC;
                        accept    = 1'b1;
                    end
                end
                CALC: begin
                    iterate = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        stateNext = DONE;
                        finish    = 1'b1;
                    end
                end
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // One shift-add or restoring-divide step on the shared {accHi, accLo} pair.
    // Divide by zero needs no special case: every trial subtract succeeds,
    // giving an all-ones quotient and the dividend as remainder.
    always_comb begin
        addend  = accLo[0] ? bQ : '0;
        sum     = {1'b0, accHi} + {1'b0, addend};
        shifted = {accHi, accLo[WIDTH-1]};
        diff    = shifted - {1'b0, bQ};
        hiNext  = accHi;
        loNext  = accLo;
        if (!opQ[1]) begin
            hiNext = sum[WIDTH:1];
            loNext = {sum[0], accLo[WIDTH-1:1]};
        end else begin
            hiNext = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            loNext = {accLo[WIDTH-2:0], ~diff[WIDTH]};
        end
        // MUL/DIVU take the low word, MULHU/REMU the high word.
        result = opQ[0] ? hiNext : loNext;
    end

    // Operand capture at accept and per-cycle datapath update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ   <= '0;
            bQ    <= '0;
            destQ <= '0;
            cnt   <= '0;
            accHi <= '0;
            accLo <= '0;
        end else if (accept) begin
            opQ   <= op;
            bQ    <= srcB;
            destQ <= destReg;
            cnt   <= '0;
            accHi <= '0;
            accLo <= srcA;
        end else if (iterate) begin
            accHi <= hiNext;
            accLo <= loNext;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Registered outputs; result registers hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyQ     <= 1'b0;
            weQ       <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            busyQ <= (stateNext != IDLE);
            weQ   <= finish && (destQ != '0);
            if (finish) begin
                writeReg  <= destQ;
                writeData <= result;
            end
        end
    end

    assign busy        = busyQ;
    // A flush during DONE must still suppress the pending write.
    assign writeEnable = weQ & ~abort;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit with directed and randomized operations.
module tb_md_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned LAT = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  srcA = '0;
    logic [W-1:0]  srcB = '0;
    logic [AW-1:0] destReg = '0;
    logic          busy;
    logic          writeEnable;
    logic [AW-1:0] writeReg;
    logic [W-1:0]  writeData;

    md_unit #(.WIDTH(W), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
        .srcA(srcA), .srcB(srcB), .destReg(destReg), .busy(busy),
        .writeEnable(writeEnable), .writeReg(writeReg), .writeData(writeData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] r;
        logic [W-1:0]  d;
        int            due;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference results from plain unsigned arithmetic.
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every write must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (writeEnable) begin
                if (sb.size() == 0) begin
                    chk("unexpectedWrite", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("writeReg", writeReg, e.r);
                    chk("writeData", writeData, e.d);
                    chk("writeCycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("missingWrite", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    // Wait for idle, present one operation, return just after its accept edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, input bit expWrite);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) chk("idleTimeout", 1, 0);
        op = o; srcA = a; srcB = b; destReg = d; start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'($urandom_range(0, 3));
        srcA    = $urandom;
        srcB    = $urandom;
        destReg = AW'($urandom_range(0, 31));
        if (expWrite && d != 0) sb.push_back('{d, model(o, a, b), cyc + LAT});
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        if (sb.size() > 0) chk("drainTimeout", sb.size(), 0);
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk("rstBusy", busy, 0);
        chk("rstWe", writeEnable, 0);
        chk("rstReg", writeReg, 0);
        chk("rstData", writeData, 0);
        #20 rst_n = 1'b1;

        // Basic multiply with latency and busy width.
        issue(2'b00, 32'd7, 32'd6, 5'd3, 1);
        waitIdle(n);
        chk("busyCycles", n, 33);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1);

        // Back-to-back divides.
        issue(2'b10, 32'd100, 32'd7, 5'd8, 1);
        issue(2'b11, 32'd100, 32'd7, 5'd9, 1);

        // Divide by zero.
        issue(2'b10, 32'h1234, 32'd0, 5'd10, 1);
        issue(2'b11, 32'h1234, 32'd0, 5'd11, 1);
        drain();

        // start/operand changes mid-flight are ignored.
        issue(2'b00, 32'h1234_5678, 32'h0000_9ABC, 5'd12, 1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b10; srcA = 32'hDEAD_BEEF; srcB = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        drain();

        // Abort in CALC at cycle 20.
        issue(2'b00, 32'd9, 32'd9, 5'd13, 0);
        repeat (19) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abortBusy", busy, 0);

        // Abort during DONE suppresses the write.
        issue(2'b01, 32'hFFFF_0000, 32'h0001_0000, 5'd14, 0);
        repeat (LAT) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abortDoneWe", writeEnable, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abortDoneBusy", busy, 0);
        repeat (5) @(negedge clk);

        // Reset in the middle of a divide.
        issue(2'b10, 32'hFFFF_FFF0, 32'd13, 5'd15, 0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midRstBusy", busy, 0);
        chk("midRstWe", writeEnable, 0);
        chk("midRstReg", writeReg, 0);
        chk("midRstData", writeData, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("postRstBusy", busy, 0);

        // destReg 0 runs full latency without a write.
        issue(2'b00, 32'd3, 32'd3, 5'd0, 1);
        waitIdle(n);
        chk("zeroDestBusy", n, 33);

        // Randomized operations with occasional mid-flight start pulses.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]    o;
            logic [W-1:0]  a, b;
            logic [AW-1:0] d;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 9) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            d = ($urandom_range(0, 9) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
            issue(o, a, b, d, 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 28)) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
